// File: rtl/game_timing_pkg.sv
// game_timing_pkg: shared tick-generator state type, default timing constants and width helper
package game_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} tick_state_t;

  localparam int PERIOD_NORMAL_DEF = 833333;
  localparam int PERIOD_SLOW_DEF   = 1666666;
  localparam int SLOW_TICKS_DEF    = 150;

  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: cycle divider with clear/advance/hold control and a terminal-count compare
module tick_prescaler #(
  parameter int W = 3
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  input  logic [W-1:0] last,
  output logic         term
);

  logic [W-1:0] div;

  // >= so that a period shrinking mid-count still terminates immediately
  assign term = div >= last;

  // divider: cleared when idle, advances or wraps while running, holds otherwise
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear)
      div <= '0;
    else if (run)
      div <= term ? '0 : div + 1'b1;
  end

endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: game-tick strobe generator with normal/slow rates, slow window and pause gating
module game_tick_gen
  import game_timing_pkg::*;
#(
  parameter int PERIOD_NORMAL = PERIOD_NORMAL_DEF,
  parameter int PERIOD_SLOW   = PERIOD_SLOW_DEF,
  parameter int SLOW_TICKS    = SLOW_TICKS_DEF
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              pause,
  input  logic                              slow_req,
  output logic                              tick,
  output logic                              slow_active,
  output logic [$clog2(SLOW_TICKS+1)-1:0]   slow_remaining
);

  localparam int DW = cnt_width(PERIOD_SLOW);
  localparam int RW = $clog2(SLOW_TICKS + 1);

  tick_state_t   state, state_nxt;
  logic          run, clear, term, fire;
  logic [DW-1:0] last;

  // next state and prescaler controls; a dropped enable overrides every state
  always_comb begin
    state_nxt = !enable ? IDLE : (state == RUN || state == PAUSE) ? (pause ? PAUSE : RUN) : RUN;
    run       = enable && state == RUN;
    clear     = !enable || state == IDLE;
    last      = slow_active ? DW'(PERIOD_SLOW - 1) : DW'(PERIOD_NORMAL - 1);
    fire      = run && term;
  end

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  tick_prescaler #(.W(DW)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (clear),
    .run      (run),
    .last     (last),
    .term     (term)
  );

  // registered one-cycle tick strobe
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      tick <= 1'b0;
    else
      tick <= fire;
  end

  // slow window: a request reloads (beating a same-edge decrement), each slow tick counts down
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      slow_active    <= 1'b0;
      slow_remaining <= '0;
    end else if (slow_req) begin
      slow_active    <= 1'b1;
      slow_remaining <= RW'(SLOW_TICKS);
    end else if (fire && slow_active) begin
      slow_active    <= slow_remaining != RW'(1);
      slow_remaining <= slow_remaining - 1'b1;
    end
  end

endmodule
